sfx_player: RTL and testbench

Parametrised multi-channel sound-effect generator, the successor to the fixed single-tune audio player. Each channel plays a square-wave tone of programmable half-period for a programmable number of prescaler ticks when triggered by game logic (paddle hit, block break, ball lost). Channels are mixed by a first-order sigma-delta modulator into the one-bit `AUDIO` pin.

---
 rtl/sfx_player.sv | 161 ++++++++++++++++
 tb/tb_sfx_player.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_player.sv
// Multi-channel square-wave sound-effect player with first-order sigma-delta mixing to a 1-bit PDM pin.
// Optional build macro SFX_SWEEP_EN adds a per-channel falling-pitch sweep (SWEEP input).

module sfx_channel #(
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                trig,
  input  logic [PERIOD_W-1:0] period,
  input  logic [DUR_W-1:0]    duration,
`ifdef SFX_SWEEP_EN
  input  logic                sweep,
`endif
  output logic                busy,
  output logic                phase
);
  localparam logic [PERIOD_W-1:0] P_ONE = PERIOD_W'(1);
  localparam logic [DUR_W-1:0]    D_ONE = DUR_W'(1);

  logic [PERIOD_W-1:0] hcnt, hper;
  logic [DUR_W-1:0]    dcnt;
  logic                start;

  assign start = trig && (duration != '0);

`ifdef SFX_SWEEP_EN
  logic                sweep_q;
  logic [PERIOD_W:0]   hper_sum;
  logic [PERIOD_W-1:0] hper_swept;

  // hper + hper/16 + 1, clamped at all-ones
  assign hper_sum   = {1'b0, hper} + {5'b0, hper[PERIOD_W-1:4]} + (PERIOD_W+1)'(1);
  assign hper_swept = hper_sum[PERIOD_W] ? '1 : hper_sum[PERIOD_W-1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      phase <= 1'b0;
      hcnt  <= '0;
      hper  <= '0;
      dcnt  <= '0;
`ifdef SFX_SWEEP_EN
      sweep_q <= 1'b0;
`endif
    end else if (start) begin
      hper  <= period;
      hcnt  <= period;
      dcnt  <= duration;
      busy  <= 1'b1;
      // a zero half-period is a silent channel, so it never raises phase
      phase <= (period != '0);
`ifdef SFX_SWEEP_EN
      sweep_q <= sweep;
`endif
    end else if (busy) begin
      if (hper == '0) begin
        phase <= 1'b0;
      end else if (hcnt <= P_ONE) begin
        // <= also catches hcnt==0 left over when a swept hper leaves zero
        hcnt  <= hper;
        phase <= ~phase;
      end else begin
        hcnt <= hcnt - P_ONE;
      end
      if (tick) begin
`ifdef SFX_SWEEP_EN
        if (sweep_q) hper <= hper_swept;
`endif
        dcnt <= dcnt - D_ONE;
        if (dcnt == D_ONE) begin
          busy  <= 1'b0;
          phase <= 1'b0;
        end
      end
    end
  end
endmodule

module sfx_player #(
  parameter int CHANNELS = 2,
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 10,
  parameter int TICK_DIV = 40000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [CHANNELS-1:0]          TRIG,
  input  logic [CHANNELS*PERIOD_W-1:0] PERIOD,
  input  logic [CHANNELS*DUR_W-1:0]    DURATION,
`ifdef SFX_SWEEP_EN
  input  logic [CHANNELS-1:0]          SWEEP,
`endif
  output logic [CHANNELS-1:0]          BUSY,
  output logic                         AUDIO
);
  localparam int LW = $clog2(CHANNELS + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [LW:0] CH_N = (LW+1)'(CHANNELS);

  logic [TW-1:0]       pcnt;
  logic                tick;
  logic [CHANNELS-1:0] phase;
  logic [LW-1:0]       level, acc;
  logic [LW:0]         sum;

  // shared prescaler, never restarted by triggers
  assign tick = (pcnt == TW'(TICK_DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + TW'(1);
  end

  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      sfx_channel #(
        .PERIOD_W (PERIOD_W),
        .DUR_W    (DUR_W)
      ) u_ch (
        .clk      (CLK),
        .rst      (RESET),
        .tick     (tick),
        .trig     (TRIG[c]),
        .period   (PERIOD[c*PERIOD_W +: PERIOD_W]),
        .duration (DURATION[c*DUR_W +: DUR_W]),
`ifdef SFX_SWEEP_EN
        .sweep    (SWEEP[c]),
`endif
        .busy     (BUSY[c]),
        .phase    (phase[c])
      );
    end
  endgenerate

  always_comb begin
    level = '0;
    for (int i = 0; i < CHANNELS; i++) level = level + LW'(BUSY[i] & phase[i]);
  end

  assign sum = {1'b0, acc} + {1'b0, level};

  // first-order sigma-delta: pulse density tracks level/CHANNELS
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc   <= '0;
      AUDIO <= 1'b0;
    end else if (sum >= CH_N) begin
      acc   <= LW'(sum - CH_N);
      AUDIO <= 1'b1;
    end else begin
      acc   <= sum[LW-1:0];
      AUDIO <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sfx_player.sv
// Bench for sfx_player: a behavioural model pushes expected {BUSY,AUDIO} per edge, scenario tasks pop and compare.
module tb_sfx_player;
  localparam int CH = 2;
  localparam int PW = 16;
  localparam int DW = 10;
  localparam int TD = 10;

  logic               CLK = 1'b0;
  logic               RESET;
  logic [CH-1:0]      TRIG;
  logic [CH*PW-1:0]   PERIOD;
  logic [CH*DW-1:0]   DURATION;
  logic [CH-1:0]      BUSY;
  logic               AUDIO;
`ifdef SFX_SWEEP_EN
  logic [CH-1:0]      SWEEP = '0;
`endif

  sfx_player #(.CHANNELS(CH), .PERIOD_W(PW), .DUR_W(DW), .TICK_DIV(TD)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .TRIG     (TRIG),
    .PERIOD   (PERIOD),
    .DURATION (DURATION),
`ifdef SFX_SWEEP_EN
    .SWEEP    (SWEEP),
`endif
    .BUSY     (BUSY),
    .AUDIO    (AUDIO)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [2:0] e;
  logic [2:0] sb[$];

  // Reference model: phase derived from elapsed cycles since the trigger
  int mpres = 0;
  int macc = 0;
  bit mbusy[CH];
  int mk[CH], mper[CH], mdur[CH];

  initial begin
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        mpres = 0;
        macc  = 0;
        for (int c = 0; c < CH; c++) begin
          mbusy[c] = 0; mk[c] = 0; mper[c] = 0; mdur[c] = 0;
        end
        sb.delete();
      end else begin
        bit tk;
        bit aud;
        int lvl, sm, p, d;
        tk = (mpres == TD - 1);
        mpres = tk ? 0 : mpres + 1;
        lvl = 0;
        for (int c = 0; c < CH; c++)
          if (mbusy[c] && mper[c] != 0 && ((mk[c] / mper[c]) % 2 == 0)) lvl++;
        sm  = macc + lvl;
        aud = (sm >= CH);
        macc = aud ? sm - CH : sm;
        for (int c = 0; c < CH; c++) begin
          p = int'(PERIOD[c*PW +: PW]);
          d = int'(DURATION[c*DW +: DW]);
          if (TRIG[c] && d != 0) begin
            mbusy[c] = 1; mk[c] = 0; mper[c] = p; mdur[c] = d;
          end else if (mbusy[c]) begin
            mk[c]++;
            if (tk) begin
              mdur[c]--;
              if (mdur[c] == 0) mbusy[c] = 0;
            end
          end
        end
        sb.push_back({mbusy[1], mbusy[0], aud});
      end
    end
  end

  task automatic test_reset;
    int bad;
    RESET = 1'b1; TRIG = '0; PERIOD = '0; DURATION = '0;
    repeat (5) @(negedge CLK);
    checks++;
    if ({BUSY, AUDIO} !== 3'b000) begin
      errors++; $display("FAIL reset_state: got %b exp 000", {BUSY, AUDIO});
    end
    RESET = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL idle: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL idle cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if (BUSY !== 2'b00 || AUDIO !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet: active cycles %0d exp 0", bad); end
  endtask

  task automatic test_single_tone;
    int bcnt, hi_a, hi_b;
    bcnt = 0; hi_a = 0; hi_b = 0;
    PERIOD = {16'd0, 16'd4}; DURATION = {10'd0, 10'd3}; TRIG = 2'b01;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL tone: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL tone cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if (i == 0) TRIG = '0;
      if (BUSY[0]) bcnt++;
      if (i >= 1 && i <= 4 && AUDIO) hi_a++;
      if (i >= 5 && i <= 8 && AUDIO) hi_b++;
    end
    checks++;
    if (bcnt < 21 || bcnt > 30) begin errors++; $display("FAIL tone_len: got %0d exp 21..30", bcnt); end
    checks++;
    if (hi_a != 2) begin errors++; $display("FAIL tone_density_hi: got %0d exp 2", hi_a); end
    checks++;
    if (hi_b != 0) begin errors++; $display("FAIL tone_density_lo: got %0d exp 0", hi_b); end
  endtask

  task automatic test_two_channels;
    int ahi;
    ahi = 0;
    PERIOD = {16'd5, 16'd3}; DURATION = {10'd5, 10'd5}; TRIG = 2'b11;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL two_ch: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL two_ch cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if (i == 0) begin
        TRIG = '0;
        checks++;
        if (BUSY !== 2'b11) begin errors++; $display("FAIL two_ch_busy: got %b exp 11", BUSY); end
      end
      if (i >= 1 && i <= 3 && AUDIO === 1'b1) ahi++;
    end
    checks++;
    if (ahi != 3) begin errors++; $display("FAIL two_ch_full: got %0d exp 3", ahi); end
  endtask

  task automatic test_edge_cases;
    int bcnt, acnt, gap, ri;
    bit done;
    // zero duration is ignored
    bcnt = 0;
    PERIOD = {16'd7, 16'd0}; DURATION = '0; TRIG = 2'b10;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL dur0: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL dur0 cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if (i == 0) TRIG = '0;
      if (BUSY !== 2'b00) bcnt++;
    end
    checks++;
    if (bcnt != 0) begin errors++; $display("FAIL dur0_busy: got %0d exp 0", bcnt); end
    // silent channel: busy but no audio
    bcnt = 0; acnt = 0;
    PERIOD = '0; DURATION = {10'd0, 10'd2}; TRIG = 2'b01;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL per0: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL per0 cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if (i == 0) TRIG = '0;
      if (BUSY[0]) bcnt++;
      if (AUDIO !== 1'b0) acnt++;
    end
    checks++;
    if (bcnt < 11 || bcnt > 20) begin errors++; $display("FAIL per0_busy: got %0d exp 11..20", bcnt); end
    checks++;
    if (acnt != 0) begin errors++; $display("FAIL per0_audio: got %0d exp 0", acnt); end
    // retrigger on the expiry tick keeps BUSY continuous
    gap = 0; ri = 0; done = 0;
    PERIOD = {16'd0, 16'd4}; DURATION = {10'd0, 10'd1}; TRIG = 2'b01;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL retrig: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL retrig cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if ((!done || i <= ri + 5) && BUSY[0] !== 1'b1) gap++;
      TRIG = '0;
      if (!done && mpres == TD - 1) begin
        DURATION = {10'd0, 10'd2}; TRIG = 2'b01; done = 1; ri = i;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL retrig_wait: tick not reached got 0 exp 1"); end
    checks++;
    if (gap != 0) begin errors++; $display("FAIL retrig_gap: got %0d exp 0", gap); end
  endtask

  task automatic test_async_reset;
    int bcnt;
    PERIOD = {16'd2, 16'd2}; DURATION = {10'd5, 10'd5}; TRIG = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL areset: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL areset cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if (i == 0) TRIG = '0;
    end
    checks++;
    if ({BUSY, AUDIO} !== 3'b111) begin errors++; $display("FAIL areset_pre: got %b exp 111", {BUSY, AUDIO}); end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if ({BUSY, AUDIO} !== 3'b000) begin errors++; $display("FAIL areset_async: got %b exp 000", {BUSY, AUDIO}); end
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    // prescaler restarts at 0, so a 1-tick tone lasts exactly TD-1 cycles
    bcnt = 0;
    PERIOD = {16'd0, 16'd3}; DURATION = {10'd0, 10'd1}; TRIG = 2'b01;
    for (int i = 0; i < 25; i++) begin
      @(negedge CLK);
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL post_reset: scoreboard empty"); end
      else begin
        e = sb.pop_front();
        if ({BUSY, AUDIO} !== e) begin
          errors++; $display("FAIL post_reset cyc %0d: got %b exp %b", i, {BUSY, AUDIO}, e);
        end
      end
      if (i == 0) TRIG = '0;
      if (BUSY[0]) bcnt++;
    end
    checks++;
    if (bcnt != TD - 1) begin errors++; $display("FAIL prescaler_restart: got %0d exp %0d", bcnt, TD - 1); end
  endtask

`ifdef SFX_SWEEP_EN
  task automatic test_sweep;
    int exp_h[4];
    int idx;
    exp_h = '{32, 35, 38, 41};
    idx = 0;
    PERIOD = {16'd0, 16'd32}; DURATION = {10'd0, 10'd4}; SWEEP = 2'b01; TRIG = 2'b01;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      sb.delete();
      if (i == 0) begin
        TRIG = '0;
        checks++;
        if (int'(dut.g_ch[0].u_ch.hper) != exp_h[0]) begin
          errors++; $display("FAIL sweep_hper0: got %0d exp %0d", dut.g_ch[0].u_ch.hper, exp_h[0]);
        end
      end else if (mpres == 0 && idx < 3) begin
        idx++;
        checks++;
        if (int'(dut.g_ch[0].u_ch.hper) != exp_h[idx]) begin
          errors++; $display("FAIL sweep_hper%0d: got %0d exp %0d", idx, dut.g_ch[0].u_ch.hper, exp_h[idx]);
        end
      end
    end
    PERIOD = {16'd0, 16'hFFFF}; DURATION = {10'd0, 10'd3}; TRIG = 2'b01;
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      sb.delete();
      if (i == 0) TRIG = '0;
    end
    checks++;
    if (dut.g_ch[0].u_ch.hper !== 16'hFFFF) begin
      errors++; $display("FAIL sweep_sat: got %0d exp 65535", dut.g_ch[0].u_ch.hper);
    end
    SWEEP = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_tone();
    test_two_channels();
    test_edge_cases();
    test_async_reset();
`ifdef SFX_SWEEP_EN
    test_sweep();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
